// File: rtl/memory_serial_reader.sv
// ----------------------------------------------------------------------------
// memory_serial_reader
//
// Purpose:
//    A DEPTH x WIDTH bank of storage words with a parallel write port and a
//    bit-serial read port. A read request snapshots one stored word into a
//    shift register and streams it out LSB-first under a valid/ready
//    handshake. The write port is independent of the read machine, so the
//    snapshot is what keeps an in-flight stream immune to later writes.
//
// Ports:
//    clk        in   1      rising-edge clock
//    reset      in   1      asynchronous, active-high reset
//    load_flag  in   1      write enable: load_word -> mem[load_addr]
//    load_addr  in   AW     write address (>= DEPTH is ignored)
//    load_word  in   WIDTH  write data
//    read_req   in   1      start a serial read (accepted only when idle)
//    read_addr  in   AW     read address, sampled when read_req is accepted
//    read_busy  out  1      read in progress (fetch, shift or done phase)
//    outbit_0   out  1      current serial bit, LSB first
//    out_valid  out  1      serial bit presented
//    out_ready  in   1      consumer takes the bit when out_valid & out_ready
//    out_last   out  1      marks the final (MSB) bit of the word
//    read_done  out  1      one-cycle pulse after the last bit is taken
//
// All outputs are registers; no input reaches an output combinationally.
// ----------------------------------------------------------------------------
module memory_serial_reader #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_flag,
   input  logic [AW-1:0]    load_addr,
   input  logic [WIDTH-1:0] load_word,
   input  logic             read_req,
   input  logic [AW-1:0]    read_addr,
   output logic             read_busy,
   output logic             outbit_0,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             read_done
);

   localparam int            CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   logic [WIDTH-1:0] mem_r [DEPTH];
   state_t           state_r;
   logic [AW-1:0]    addr_q_r;
   logic [WIDTH-1:0] shreg_r;
   logic [CW-1:0]    count_r;
   logic [WIDTH-1:0] fetch_word_s;
   logic [WIDTH-1:0] shreg_next_s;
   logic [CW-1:0]    count_next_s;

   // Write port: each implemented word decodes its own address, so an
   // address at or beyond DEPTH matches no word and the write is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (load_flag) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (load_addr == AW'(i)) begin
               mem_r[i] <= load_word;
            end
         end
      end
   end

   // Read mux as an AND-OR tree over the words; an out-of-range latched
   // address selects nothing and yields an all-zero word.
   always_comb begin
      fetch_word_s = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fetch_word_s = fetch_word_s | (mem_r[i] & {WIDTH{addr_q_r == AW'(i)}});
      end
   end

   // Next shift-register contents and bit index for an accepted bit.
   always_comb begin
      shreg_next_s = shreg_r >> 1;
      count_next_s = count_r + CW'(1);
   end

   // Read sequencer with registered outputs. FETCH copies the word from
   // storage using the pre-edge memory contents, so a write landing on the
   // same edge is not part of the snapshot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         addr_q_r  <= '0;
         shreg_r   <= '0;
         count_r   <= '0;
         read_busy <= 1'b0;
         outbit_0  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         read_done <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               read_done <= 1'b0;
               if (read_req) begin
                  addr_q_r  <= read_addr;
                  read_busy <= 1'b1;
                  state_r   <= ST_FETCH;
               end
            end

            ST_FETCH: begin
               shreg_r   <= fetch_word_s;
               count_r   <= '0;
               outbit_0  <= fetch_word_s[0];
               out_last  <= (LAST_IDX == '0);
               out_valid <= 1'b1;
               state_r   <= ST_SHIFT;
            end

            ST_SHIFT: begin
               // out_valid is always high here, so out_ready alone is the
               // handshake. Without it everything holds.
               if (out_ready) begin
                  if (count_r == LAST_IDX) begin
                     // Count stays at WIDTH-1; it is reloaded on the next fetch.
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     outbit_0  <= 1'b0;
                     read_done <= 1'b1;
                     state_r   <= ST_DONE;
                  end else begin
                     shreg_r  <= shreg_next_s;
                     count_r  <= count_next_s;
                     outbit_0 <= shreg_next_s[0];
                     out_last <= (count_next_s == LAST_IDX);
                  end
               end
            end

            ST_DONE: begin
               read_done <= 1'b0;
               read_busy <= 1'b0;
               state_r   <= ST_IDLE;
            end

            default: begin
               state_r   <= ST_IDLE;
               read_busy <= 1'b0;
               outbit_0  <= 1'b0;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               read_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_serial_reader.sv
// ----------------------------------------------------------------------------
// tb_memory_serial_reader
//
// Self-checking bench for memory_serial_reader (WIDTH=8, DEPTH=3, AW=2 so
// that address 3 is out of range). A reference memory array plus the
// snapshot-then-stream rule give the expected bit sequence; directed reads
// cover the listed scenarios and a randomized loop mixes writes, addresses,
// ready patterns and stray read requests.
// ----------------------------------------------------------------------------
module tb_memory_serial_reader;

   localparam int WIDTH = 8;
   localparam int DEPTH = 3;
   localparam int AW    = 2;

   logic             clk;
   logic             reset;
   logic             load_flag;
   logic [AW-1:0]    load_addr;
   logic [WIDTH-1:0] load_word;
   logic             read_req;
   logic [AW-1:0]    read_addr;
   logic             read_busy;
   logic             outbit_0;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic             read_done;

   logic [WIDTH-1:0] ref_mem [0:3];
   int               vec_cnt;
   int               err_cnt;

   memory_serial_reader #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .load_flag (load_flag),
      .load_addr (load_addr),
      .load_word (load_word),
      .read_req  (read_req),
      .read_addr (read_addr),
      .read_busy (read_busy),
      .outbit_0  (outbit_0),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .read_done (read_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic chk(input string tag, input logic obs, input logic want);
      vec_cnt++;
      if (obs !== want) begin
         err_cnt++;
         $display("FAIL %s: observed %b, expected %b at %0t", tag, obs, want, $time);
      end
   endtask

   // One clock: the reference memory takes any in-range write at the edge.
   task automatic step();
      @(posedge clk);
      if (!reset && load_flag && (int'(load_addr) < DEPTH)) begin
         ref_mem[load_addr] = load_word;
      end
      @(negedge clk);
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      load_flag = 1'b1;
      load_addr = a;
      load_word = d;
      step();
      load_flag = 1'b0;
   endtask

   // Full read. mode: 0 ready held high, 1 ready toggling, 2 random ready.
   // wr_cycle: cycle (0 = request cycle, 1 = fetch cycle, ...) carrying a
   // write of wdata to waddr; spam drives random read_req while busy.
   task automatic do_read(input logic [AW-1:0] addr, input int mode, input int wr_cycle,
                          input logic [AW-1:0] waddr, input logic [WIDTH-1:0] wdata,
                          input bit spam);
      logic [WIDTH-1:0] snap;
      int               nbits;
      bit               fin;
      chk("idle_busy", read_busy, 1'b0);
      read_req  = 1'b1;
      read_addr = addr;
      out_ready = 1'b1;
      load_flag = (wr_cycle == 0);
      load_addr = waddr;
      load_word = wdata;
      step();
      // Word seen by the read: memory after the request edge, before the fetch edge.
      snap  = (int'(addr) < DEPTH) ? ref_mem[addr] : '0;
      nbits = 0;
      fin   = 1'b0;
      for (int c = 1; c < 200 && !fin; c++) begin
         read_req  = spam ? 1'($urandom_range(0, 1)) : 1'b0;
         read_addr = AW'($urandom_range(0, 3));
         load_flag = (c == wr_cycle);
         load_addr = waddr;
         load_word = wdata;
         if (mode == 0) begin
            out_ready = 1'b1;
         end else if (mode == 1) begin
            out_ready = (c % 2 == 0);
         end else begin
            out_ready = 1'($urandom_range(0, 1));
         end
         chk("busy", read_busy, 1'b1);
         chk("valid", out_valid, (c >= 2) && (nbits < WIDTH));
         chk("done", read_done, nbits == WIDTH);
         if (out_valid) begin
            chk("bit", outbit_0, (nbits < WIDTH) ? snap[nbits[2:0]] : 1'b0);
            chk("last", out_last, nbits == WIDTH - 1);
            if (out_ready) nbits++;
         end
         if (read_done) fin = 1'b1;
         step();
      end
      chk("timeout_done", fin, 1'b1);
      read_req  = 1'b0;
      load_flag = 1'b0;
      chk("busy_drop", read_busy, 1'b0);
      chk("done_pulse", read_done, 1'b0);
      chk("valid_idle", out_valid, 1'b0);
   endtask

   // Reset after three accepted bits: stream aborts at once, no read_done.
   task automatic reset_mid_read();
      logic [WIDTH-1:0] snap;
      read_req  = 1'b1;
      read_addr = 2'd1;
      out_ready = 1'b1;
      load_flag = 1'b0;
      step();
      read_req = 1'b0;
      snap     = ref_mem[1];
      step();
      repeat (3) step();
      chk("pre_rst_valid", out_valid, 1'b1);
      chk("pre_rst_bit3", outbit_0, snap[3]);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_busy", read_busy, 1'b0);
      chk("rst_last", out_last, 1'b0);
      chk("rst_done", read_done, 1'b0);
      for (int i = 0; i < 4; i++) ref_mem[i] = '0;
      @(negedge clk);
      chk("rst_hold_done", read_done, 1'b0);
      reset = 1'b0;
      step();
      chk("post_rst_done", read_done, 1'b0);
      chk("post_rst_busy", read_busy, 1'b0);
   endtask

   initial begin
      vec_cnt   = 0;
      err_cnt   = 0;
      reset     = 1'b1;
      load_flag = 1'b0;
      load_addr = '0;
      load_word = '0;
      read_req  = 1'b0;
      read_addr = '0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) ref_mem[i] = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", read_busy, 1'b0);
      chk("reset_valid", out_valid, 1'b0);
      chk("reset_bit", outbit_0, 1'b0);
      chk("reset_last", out_last, 1'b0);
      chk("reset_done", read_done, 1'b0);
      reset = 1'b0;
      step();

      // Basic read of A5 with ready held high, then with ready toggling.
      write_word(2'd1, 8'hA5);
      do_read(2'd1, 0, -1, 2'd0, 8'h00, 1'b0);
      do_read(2'd1, 1, -1, 2'd0, 8'h00, 1'b0);

      // Write to the streamed address mid-shift does not disturb the stream.
      write_word(2'd2, 8'h3C);
      do_read(2'd2, 0, 5, 2'd2, 8'hFF, 1'b0);
      do_read(2'd2, 0, -1, 2'd0, 8'h00, 1'b0);

      // Stray requests while busy; write in the fetch cycle is not captured.
      write_word(2'd0, 8'h5A);
      do_read(2'd0, 2, 1, 2'd0, 8'hC3, 1'b1);
      do_read(2'd0, 0, -1, 2'd1, 8'h00, 1'b0);
      // Write in the request cycle lands before the fetch and is captured.
      do_read(2'd0, 0, 0, 2'd0, 8'h96, 1'b0);

      // Reset mid-stream, then every address reads back zero.
      reset_mid_read();
      for (int a = 0; a < 4; a++) do_read(AW'(a), 2, -1, 2'd0, 8'h00, 1'b0);

      // Out-of-range address: write ignored, read yields zeros.
      write_word(2'd3, 8'h77);
      do_read(2'd3, 0, -1, 2'd0, 8'h00, 1'b0);

      // Randomized mix.
      repeat (25) begin
         repeat ($urandom_range(0, 3)) begin
            write_word(AW'($urandom_range(0, 3)), WIDTH'($urandom));
         end
         do_read(AW'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 14)), AW'($urandom_range(0, 3)),
                 WIDTH'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
